// File: rtl/pixel_pkg.sv
// Shared types and constants for the pixel stream reader and its processors.
// COLOR_SIZE    : width of one colour channel / threshold value
// PIXEL_SIZE    : four channels per pixel
// FLUSH_WORDS   : zero words appended after a frame to drain the processor pipeline
// mode_e        : processor operating mode
// reader_state_t: reader FSM state
// reader_cfg_t  : per-frame configuration latched on start
package pixel_pkg;

  localparam int unsigned COLOR_SIZE  = 8;
  localparam int unsigned PIXEL_SIZE  = 4 * COLOR_SIZE;
  localparam int unsigned FLUSH_WORDS = 3;
  localparam int unsigned FLUSH_CNT_W = 2;
  localparam int unsigned MODE_W      = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_NONE   = 2'd0,
    MODE_THRESH = 2'd1,
    MODE_BRIGHT = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } reader_state_t;

  typedef struct packed {
    mode_e                 mode;
    logic [COLOR_SIZE-1:0] val;
  } reader_cfg_t;

endpackage

// File: rtl/reader_addr_gen.sv
// Address/length sequencer for the pixel stream reader.
// On load it issues len consecutive read strobes starting at base, with the
// address wrapping modulo 2^ADDR_WIDTH, and flags the final read with last.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   load       : begin a new burst (only asserted while idle with len != 0)
//   base       : first word address
//   len        : burst length in words
//   rd_en      : registered read strobe
//   addr       : registered read address
//   last       : registered, high with the final read of the burst
module reader_addr_gen #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last
);

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic                  rd_en_q, rd_en_d;
  logic                  last_q, last_d;

  // rem_q holds the number of reads still to issue after the current one
  always_comb begin
    addr_d  = addr_q;
    rem_d   = rem_q;
    rd_en_d = rd_en_q;
    last_d  = last_q;
    if (load) begin
      addr_d  = base;
      rem_d   = len - LEN_WIDTH'(1);
      rd_en_d = (len != '0);
      last_d  = (len == LEN_WIDTH'(1));
    end else if (rd_en_q) begin
      if (rem_q == '0) begin
        rd_en_d = 1'b0;
        last_d  = 1'b0;
      end else begin
        addr_d  = addr_q + ADDR_WIDTH'(1);
        rem_d   = rem_q - LEN_WIDTH'(1);
        last_d  = (rem_q == LEN_WIDTH'(1));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      rem_q   <= '0;
      rd_en_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      rd_en_q <= rd_en_d;
      last_q  <= last_d;
    end
  end

  assign rd_en = rd_en_q;
  assign addr  = addr_q;
  assign last  = last_q;

endmodule

// File: rtl/pixel_stream_reader.sv
// Source end of the pixel processor stream. Fetches a frame of DATA_WIDTH
// words from a synchronous-read SRAM and streams them as vld/last_data/data_in,
// holding mode/proc_val stable for the whole frame. vld stays high without
// gaps inside a frame because the processors clear their state when vld drops.
// Optional build macro: PIXEL_READER_FLUSH_EN appends FLUSH_WORDS zero words
// (vld=1, last_data=0) after the last real word to drain the processors.
// Ports:
//   clk, rst_n    : clock, async active-low reset
//   start         : 1-cycle frame request, ignored while busy
//   base_addr     : first word address (sampled on start)
//   num_words     : frame length in words (sampled on start)
//   cfg_mode      : processor mode (sampled on start)
//   cfg_val       : threshold/brightness value (sampled on start)
//   mem_rd_en     : SRAM read strobe
//   mem_addr      : SRAM read address
//   mem_rd_data   : SRAM read data, valid one cycle after mem_rd_en
//   vld           : stream word valid
//   last_data     : final real word of the frame
//   data_in       : stream word
//   mode          : latched cfg_mode
//   proc_val      : latched cfg_val
//   busy          : frame in progress
//   done          : 1-cycle pulse after the final stream word
module pixel_stream_reader
  import pixel_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  num_words,
  input  logic [MODE_W-1:0]     cfg_mode,
  input  logic [COLOR_SIZE-1:0] cfg_val,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  vld,
  output logic                  last_data,
  output logic [DATA_WIDTH-1:0] data_in,
  output logic [MODE_W-1:0]     mode,
  output logic [COLOR_SIZE-1:0] proc_val,
  output logic                  busy,
  output logic                  done
);

  reader_state_t state_q, state_d;

  logic                  load_c;
  logic                  gen_rd_en;
  logic                  gen_last;

  logic                  pend_q, pend_d;
  logic                  pend_last_q, pend_last_d;
  logic                  vld_q, vld_d;
  logic                  last_data_q, last_data_d;
  logic [DATA_WIDTH-1:0] data_in_q, data_in_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  reader_cfg_t           cfg_q, cfg_d;

`ifdef PIXEL_READER_FLUSH_EN
  logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
`endif

  // Read request sequencing
  reader_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH)
  ) u_addr_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load_c),
    .base  (base_addr),
    .len   (num_words),
    .rd_en (gen_rd_en),
    .addr  (mem_addr),
    .last  (gen_last)
  );

  assign mem_rd_en = gen_rd_en;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
      vld_q       <= 1'b0;
      last_data_q <= 1'b0;
      data_in_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_q       <= '0;
`ifdef PIXEL_READER_FLUSH_EN
      flush_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      pend_last_q <= pend_last_d;
      vld_q       <= vld_d;
      last_data_q <= last_data_d;
      data_in_q   <= data_in_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cfg_q       <= cfg_d;
`ifdef PIXEL_READER_FLUSH_EN
      flush_cnt_q <= flush_cnt_d;
`endif
    end
  end

  // Next state. DONE is the cycle done is visible; it accepts a new start
  // exactly like IDLE so frames can run back to back.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          state_d = (num_words != '0) ? ST_READ : ST_DONE;
        end
      end
      ST_READ: begin
        // last_data_q high means the final real word is on the stream now
        if (last_data_q) begin
`ifdef PIXEL_READER_FLUSH_EN
          state_d = ST_FLUSH;
`else
          state_d = ST_DONE;
`endif
        end
      end
      ST_FLUSH: begin
`ifdef PIXEL_READER_FLUSH_EN
        if (flush_cnt_q == FLUSH_CNT_W'(FLUSH_WORDS)) begin
          state_d = ST_DONE;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output next values. Read data lands one cycle after the strobe, so the
  // strobe is delayed once (pend) and the stream word is registered from it.
  always_comb begin
    load_c      = 1'b0;
    cfg_d       = cfg_q;
    pend_d      = gen_rd_en;
    pend_last_d = gen_rd_en & gen_last;
    vld_d       = pend_q;
    last_data_d = pend_last_q;
    data_in_d   = pend_q ? mem_rd_data : '0;
    busy_d      = (state_d == ST_READ) || (state_d == ST_FLUSH);
    done_d      = (state_d == ST_DONE);

    if ((state_q == ST_IDLE || state_q == ST_DONE) && start && (num_words != '0)) begin
      load_c     = 1'b1;
      cfg_d.mode = mode_e'(cfg_mode);
      cfg_d.val  = cfg_val;
    end

`ifdef PIXEL_READER_FLUSH_EN
    flush_cnt_d = flush_cnt_q;
    // Zero words drain the processor pipeline after the last real word
    if (state_d == ST_FLUSH) begin
      vld_d       = 1'b1;
      flush_cnt_d = (state_q == ST_FLUSH) ? flush_cnt_q + FLUSH_CNT_W'(1)
                                          : FLUSH_CNT_W'(1);
    end
`endif
  end

  assign vld       = vld_q;
  assign last_data = last_data_q;
  assign data_in   = data_in_q;
  assign mode      = cfg_q.mode;
  assign proc_val  = cfg_q.val;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_pixel_stream_reader.sv
// Testbench for pixel_stream_reader: directed and randomized frames against a
// timeline model (cycle offsets from the start-sampling edge) and a memory image.
`timescale 1ns/1ps
module tb_pixel_stream_reader;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 16;
  localparam int unsigned LW = 16;
`ifdef PIXEL_READER_FLUSH_EN
  localparam int FL = 3;
`else
  localparam int FL = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [LW-1:0] num_words = '0;
  logic [1:0]    cfg_mode = '0;
  logic [7:0]    cfg_val = '0;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rd_data;
  logic          vld;
  logic          last_data;
  logic [DW-1:0] data_in;
  logic [1:0]    mode;
  logic [7:0]    proc_val;
  logic          busy;
  logic          done;

  pixel_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .num_words(num_words), .cfg_mode(cfg_mode), .cfg_val(cfg_val),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .vld(vld), .last_data(last_data), .data_in(data_in), .mode(mode),
    .proc_val(proc_val), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Synchronous-read SRAM
  logic [DW-1:0] mem [0:65535];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

  int errors = 0;
  int checks = 0;
  logic [1:0] exp_mode = '0;
  logic [7:0] exp_val = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One frame. The model: with the start edge as cycle 0, reads occupy cycles
  // 0..n-1, stream words 2..n+1 (+flush words), done at n+2+FL.
  task automatic run_frame(input logic [15:0] base, input logic [15:0] n,
                           input logic [1:0] md, input logic [7:0] v,
                           input bit pre, input int ign_at, input bit chain,
                           input logic [15:0] nb, input logic [15:0] nn,
                           input logic [1:0] nm, input logic [7:0] nv);
    int d;
    bit e_rd, e_vld, e_last;
    logic [31:0] e_data;
    if (!pre) begin
      start = 1'b1; base_addr = base; num_words = n; cfg_mode = md; cfg_val = v;
    end
    if (n != 0) begin
      exp_mode = md;
      exp_val  = v;
    end
    d = (n == 0) ? 0 : int'(n) + 2 + FL;
    for (int c = 0; c <= d; c++) begin
      @(negedge clk);
      if (c == 0) start = 1'b0;
      e_rd   = (n != 0) && (c < int'(n));
      e_vld  = (n != 0) && (c >= 2) && (c < int'(n) + 2 + FL);
      e_last = (n != 0) && (c == int'(n) + 1);
      e_data = (c >= 2 && c < int'(n) + 2) ? mem[16'(base + 16'(c - 2))] : 32'h0;
      check("rd_en", 64'(mem_rd_en), 64'(e_rd));
      if (e_rd) check("addr", 64'(mem_addr), 64'(16'(base + 16'(c))));
      check("vld", 64'(vld), 64'(e_vld));
      check("last", 64'(last_data), 64'(e_last));
      if (e_vld) check("data", 64'(data_in), 64'(e_data));
      check("done", 64'(done), 64'(c == d));
      check("busy", 64'(busy), 64'((n != 0) && (c < d)));
      check("mode", 64'(mode), 64'(exp_mode));
      check("pval", 64'(proc_val), 64'(exp_val));
      if (c == ign_at) begin
        start = 1'b1; base_addr = ~base; num_words = 16'd3; cfg_mode = ~md; cfg_val = ~v;
      end else if (c == ign_at + 1) begin
        start = 1'b0;
      end
      if (chain && c == d) begin
        start = 1'b1; base_addr = nb; num_words = nn; cfg_mode = nm; cfg_val = nv;
      end
    end
    if (!chain) begin
      @(negedge clk);
      check("idle_vld", 64'(vld), 64'(0));
      check("idle_done", 64'(done), 64'(0));
      check("idle_busy", 64'(busy), 64'(0));
      check("idle_rd", 64'(mem_rd_en), 64'(0));
    end
  endtask

  initial begin
    logic [15:0] cb, cn, xb, xn;
    logic [1:0]  cm, xm;
    logic [7:0]  cv, xv;
    bit          pre, ch;

    for (int i = 0; i < 65536; i++) mem[i] = 32'(i);

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_vld", 64'(vld), 64'(0));
    check("rst_rd", 64'(mem_rd_en), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_last", 64'(last_data), 64'(0));
    check("rst_mode", 64'(mode), 64'(0));
    check("rst_pval", 64'(proc_val), 64'(0));
    check("rst_data", 64'(data_in), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Basic frame, single word frame, address wrap, zero length
    run_frame(16'h0010, 16'd4, 2'd0, 8'h00, 1'b0, -1, 1'b0, '0, '0, '0, '0);
    run_frame(16'h0020, 16'd1, 2'd2, 8'h44, 1'b0, -1, 1'b0, '0, '0, '0, '0);
    run_frame(16'hFFFE, 16'd4, 2'd1, 8'h10, 1'b0, -1, 1'b0, '0, '0, '0, '0);
    run_frame(16'h0300, 16'd0, 2'd3, 8'hEE, 1'b0, -1, 1'b0, '0, '0, '0, '0);

    // Start while busy is ignored
    run_frame(16'h0200, 16'd6, 2'd2, 8'h33, 1'b0, 3, 1'b0, '0, '0, '0, '0);

    // Start accepted in the done cycle
    run_frame(16'h0040, 16'd3, 2'd0, 8'h11, 1'b0, -1, 1'b1, 16'h0050, 16'd5, 2'd1, 8'h80);
    run_frame(16'h0050, 16'd5, 2'd1, 8'h80, 1'b1, -1, 1'b0, '0, '0, '0, '0);

    // Reset in the middle of an 8-word frame
    start = 1'b1; base_addr = 16'h0100; num_words = 16'd8; cfg_mode = 2'd2; cfg_val = 8'h5A;
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      if (c == 0) start = 1'b0;
    end
    check("mid_vld_pre", 64'(vld), 64'(1));
    check("mid_data_pre", 64'(data_in), 64'(mem[16'h0101]));
    rst_n = 1'b0;
    #1;
    check("mid_vld", 64'(vld), 64'(0));
    check("mid_busy", 64'(busy), 64'(0));
    check("mid_rd", 64'(mem_rd_en), 64'(0));
    check("mid_done", 64'(done), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    exp_mode = '0;
    exp_val  = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("post_rst_done", 64'(done), 64'(0));
      check("post_rst_vld", 64'(vld), 64'(0));
      check("post_rst_mode", 64'(mode), 64'(0));
    end
    run_frame(16'h0120, 16'd8, 2'd3, 8'hC3, 1'b0, -1, 1'b0, '0, '0, '0, '0);

    // Randomized frames over random memory contents, some chained
    for (int i = 0; i < 65536; i++) mem[i] = $urandom;
    pre = 1'b0;
    xb = 16'($urandom); xn = 16'($urandom_range(0, 12)); xm = 2'($urandom); xv = 8'($urandom);
    for (int k = 0; k < 12; k++) begin
      cb = xb; cn = xn; cm = xm; cv = xv;
      xb = 16'($urandom); xn = 16'($urandom_range(0, 12)); xm = 2'($urandom); xv = 8'($urandom);
      ch = (k < 11) && ($urandom_range(0, 1) == 1);
      run_frame(cb, cn, cm, cv, pre, -1, ch, xb, xn, xm, xv);
      pre = ch;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
